// File: rtl/alu_seq_acc.sv
// alu_seq_acc: handshaked ALU with accumulator, status flags and
// multi-cycle unsigned multiply (shift-add) / divide (restoring).
// Single-cycle ops complete one clock after accept; MUL/DIV iterate
// one bit per clock for WIDTH clocks before presenting the result.
module alu_seq_acc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       flags,
    output logic             err,
    output logic [WIDTH-1:0] acc
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    // Multiplicand (MUL) or divisor (DIV), frozen at accept.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // Iteration register pair: MUL {partial hi, multiplier/product lo},
    // DIV {partial remainder, dividend/quotient}.
    logic [WIDTH-1:0] wrk_hi_q, wrk_hi_d;
    logic [WIDTH-1:0] wrk_lo_q, wrk_lo_d;
    logic             is_div_q, is_div_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   sum, diff, shl_ext, shr_ext;
    logic [WIDTH-1:0] alu_lo;
    logic             alu_c, alu_v, alu_err, alu_wr_acc;
    logic [3:0]       alu_flags;

    logic [WIDTH:0]   mul_sum, rem_sh, trial;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [3:0]       step_flags;

    // Flags are always {N,Z,C,V} with N/Z taken from the low result word.
    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    assign opa       = use_acc ? acc_q : a;
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign acc       = acc_q;

    // Single-cycle operations evaluated directly on the accept-cycle operands.
    always_comb begin
        alu_lo     = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_err    = 1'b0;
        alu_wr_acc = 1'b1;
        sum        = {1'b0, opa} + {1'b0, b};
        diff       = {1'b0, opa} - {1'b0, b};
        // One guard bit on the far side catches the last bit shifted out;
        // it stays 0 for a zero shift amount.
        shl_ext    = {1'b0, opa} << b[SHW-1:0];
        shr_ext    = {opa, 1'b0} >> b[SHW-1:0];
        case (op)
            OP_ADD: begin
                alu_lo = sum[WIDTH-1:0];
                alu_c  = sum[WIDTH];
                alu_v  = (opa[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_lo = (op == OP_CMP) ? opa : diff[WIDTH-1:0];
                alu_c  = diff[WIDTH];
                alu_v  = (opa[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
                alu_wr_acc = (op != OP_CMP);
            end
            OP_AND: alu_lo = opa & b;
            OP_OR:  alu_lo = opa | b;
            OP_XOR: alu_lo = opa ^ b;
            OP_SHL: begin
                alu_lo = shl_ext[WIDTH-1:0];
                alu_c  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_lo = shr_ext[WIDTH:1];
                alu_c  = shr_ext[0];
            end
            OP_MUL, OP_DIV: ;
            default: begin
                alu_err    = 1'b1;
                alu_wr_acc = 1'b0;
            end
        endcase
        alu_flags = alu_err ? 4'b0 : pack_flags(alu_lo, alu_c, alu_v);
    end

    // One shift-add or restoring-division step per BUSY cycle.
    always_comb begin
        mul_sum = {1'b0, wrk_hi_q} + (wrk_lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {wrk_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {wrk_lo_q[WIDTH-2:0], 1'b0};
            end
            // A zero divisor naturally yields all-ones quotient, remainder A.
            step_flags = pack_flags(step_lo, 1'b0, (opnd_q == '0));
        end else begin
            step_hi    = mul_sum[WIDTH:1];
            step_lo    = {mul_sum[0], wrk_lo_q[WIDTH-1:1]};
            step_flags = pack_flags(step_lo, 1'b0, (step_hi != '0));
        end
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        err_d    = err_q;
        opnd_d   = opnd_q;
        wrk_hi_d = wrk_hi_q;
        wrk_lo_d = wrk_lo_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL || op == OP_DIV) begin
                        is_div_d = (op == OP_DIV);
                        opnd_d   = (op == OP_DIV) ? b : opa;
                        wrk_hi_d = '0;
                        wrk_lo_d = (op == OP_DIV) ? opa : b;
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end else begin
                        res_lo_d = alu_lo;
                        res_hi_d = '0;
                        flags_d  = alu_flags;
                        err_d    = alu_err;
                        if (alu_wr_acc) acc_d = alu_lo;
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                wrk_hi_d = step_hi;
                wrk_lo_d = step_lo;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    res_lo_d = step_lo;
                    res_hi_d = step_hi;
                    flags_d  = step_flags;
                    err_d    = 1'b0;
                    acc_d    = step_lo;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset clears everything and abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            opnd_q   <= '0;
            wrk_hi_q <= '0;
            wrk_lo_q <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            opnd_q   <= opnd_d;
            wrk_hi_q <= wrk_hi_d;
            wrk_lo_q <= wrk_lo_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Bench for alu_seq_acc: directed scenarios plus randomized commands,
// checked against an arithmetic reference model with its own accumulator.
module tb_alu_seq_acc;

    localparam int W = 8;
    localparam int M = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         use_acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res_lo;
    logic [W-1:0] res_hi;
    logic [3:0]   flags;
    logic         err;
    logic [W-1:0] acc;

    int n_tests = 0;
    int n_fail  = 0;
    int model_acc = 0;

    alu_seq_acc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .use_acc(use_acc), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi), .flags(flags), .err(err), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int to_s(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    function automatic bit ovf(input int r);
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Reference: what the operation means, in plain integer arithmetic.
    function automatic void model(input int opv, input int A, input int B,
                                  output int lo, output int hi, output int fl,
                                  output int er, output bit wr);
        int c, v, sh, p;
        lo = 0; hi = 0; c = 0; v = 0; er = 0; wr = 1;
        sh = B % W;
        case (opv)
            0: begin lo = (A + B) & M; c = int'((A + B) > M); v = int'(ovf(to_s(A) + to_s(B))); end
            1: begin lo = (A - B) & M; c = int'(A < B); v = int'(ovf(to_s(A) - to_s(B))); end
            2: lo = A & B;
            3: lo = A | B;
            4: lo = A ^ B;
            5: begin lo = (A << sh) & M; c = (sh != 0) ? ((A << sh) >> W) & 1 : 0; end
            6: begin lo = A >> sh; c = (sh != 0) ? (A >> (sh - 1)) & 1 : 0; end
            7: begin lo = A; c = int'(A < B); v = int'(ovf(to_s(A) - to_s(B))); wr = 0; end
            8: begin p = A * B; lo = p & M; hi = p >> W; v = int'(hi != 0); end
            9: begin
                if (B == 0) begin lo = M; hi = A; v = 1; end
                else begin lo = A / B; hi = A % B; end
            end
            default: begin er = 1; wr = 0; end
        endcase
        fl = (er != 0) ? 0 : ((((lo >> (W - 1)) & 1) << 3) | (int'(lo == 0) << 2) | (c << 1) | v);
    endfunction

    // Issue one command, wait for its result, hold it for 'hold' cycles
    // of back-pressure, then release it.
    task automatic do_cmd(input int opv, input bit ua, input int av, input int bv,
                          input int hold, input string tag);
        int A, elo, ehi, efl, eer, elat, lat;
        bit wr;
        A = ua ? model_acc : av;
        model(opv, A, bv, elo, ehi, efl, eer, wr);
        if (wr) model_acc = elo;
        elat = (opv == 8 || opv == 9) ? W + 1 : 1;
        chk({tag, ".in_ready_idle"}, int'(in_ready), 1);
        in_valid = 1'b1; op = 4'(opv); use_acc = ua; a = 8'(av); b = 8'(bv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, ".in_ready_busy"}, int'(in_ready), 0);
            a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
            use_acc = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".res_lo"}, int'(res_lo), elo);
        chk({tag, ".res_hi"}, int'(res_hi), ehi);
        chk({tag, ".flags"}, int'(flags), efl);
        chk({tag, ".err"}, int'(err), eer);
        chk({tag, ".acc"}, int'(acc), model_acc);
        repeat (hold) begin
            in_valid = 1'($urandom); op = 4'($urandom);
            a = 8'($urandom); b = 8'($urandom); use_acc = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, int'(out_valid), 1);
            chk({tag, ".hold_ready"}, int'(in_ready), 0);
            chk({tag, ".hold_lo"}, int'(res_lo), elo);
            chk({tag, ".hold_flags"}, int'(flags), efl);
            chk({tag, ".hold_acc"}, int'(acc), model_acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".released_valid"}, int'(out_valid), 0);
        chk({tag, ".released_ready"}, int'(in_ready), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".res_lo"}, int'(res_lo), 0);
        chk({tag, ".res_hi"}, int'(res_hi), 0);
        chk({tag, ".flags"}, int'(flags), 0);
        chk({tag, ".err"}, int'(err), 0);
        chk({tag, ".acc"}, int'(acc), 0);
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        int ropv, rb;
        rst = 1'b1; in_valid = 1'b0; op = 4'd0; use_acc = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        do_cmd(0, 0, 'hF0, 'h20, 0, "add_carry");
        do_cmd(1, 0, 'h10, 'h20, 0, "sub_borrow");
        do_cmd(7, 0, 'h05, 'h05, 0, "cmp_eq");
        do_cmd(8, 0, 'hFF, 'hFF, 0, "mul_ff");
        do_cmd(9, 0, 'h64, 'h07, 0, "div");
        do_cmd(9, 0, 'h64, 'h00, 0, "div_zero");
        do_cmd(0, 0, 'h7F, 'h01, 5, "add_ovf_bp");
        do_cmd(0, 0, 3, 4, 0, "chain_add");
        do_cmd(0, 1, 'hAA, 5, 0, "chain_acc");
        do_cmd(12, 0, 'h33, 'h44, 0, "illegal");
        do_cmd(5, 0, 'h81, 0, 0, "shl_zero");
        do_cmd(6, 0, 'h81, 'h09, 0, "shr_wrap");
        do_cmd(5, 1, 0, 7, 1, "shl_acc");

        for (int i = 0; i < 150; i++) begin
            ropv = int'($urandom_range(15, 0));
            rb   = int'($urandom_range(M, 0));
            if ($urandom_range(7, 0) == 0) rb = 0;
            do_cmd(ropv, 1'($urandom), int'($urandom_range(M, 0)), rb,
                   int'($urandom_range(3, 0)), $sformatf("rand%0d_op%0d", i, ropv));
        end

        // Reset in the middle of a multiply discards it entirely.
        in_valid = 1'b1; op = 4'd8; use_acc = 1'b0; a = 8'hC3; b = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_mul.busy", int'(in_ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_acc = 0;
        chk_all_zero("mid_mul_reset");
        repeat (W + 2) @(posedge clk);
        #1;
        chk("post_reset.out_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
